// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu -- single-outstanding load/store unit between an upstream op source
// and a simple request/finish memory bus.
//
// One op is accepted at a time in IDLE. It is decoded into an access size and a
// signedness, then checked for legality: a known code, a size that fits in one
// beat, and natural alignment. An illegal op goes straight to a one-cycle
// error response. A legal load raises rd_req with a beat-aligned address until
// rd_finish. A legal store raises wr_req with lane-placed data and byte strobes
// until wr_finish. Every op ends with exactly one resp_valid cycle.
//
// Parameters
//   XLEN   : data / bus width in bits (32 or 64)
//   ADDR_W : byte address width in bits
//
// Ports
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid / req_ready         : op handshake (ready only in IDLE)
//   req_ctrl                      : op code, bit3 = store
//   req_addr / req_wdata          : byte address, LSB-aligned store data
//   rd_req / rd_addr              : read request and beat-aligned address
//   rd_finish / rd_data           : read completion and returned beat
//   wr_req / wr_addr              : write request and beat-aligned address
//   wr_data / wr_strb             : lane-placed store data and byte enables
//   wr_finish                     : write completion
//   resp_valid / resp_data        : one-cycle completion and load result
//   resp_err                      : completion was an illegal/misaligned op
// -----------------------------------------------------------------------------
module mem_lsu #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_finish,
  input  logic [XLEN-1:0]   rd_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]   wr_data,
  output logic [XLEN/8-1:0] wr_strb,
  input  logic              wr_finish,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RESP
  } state_t;

  state_t state;

  // Op decode (combinational, only consumed at the accept edge)
  logic [3:0]       dec_size;
  logic             dec_sgn;
  logic             dec_code_ok;
  logic             dec_store;
  logic [OFS_W-1:0] req_ofs;
  logic [3:0]       req_ofs_ext;
  logic [3:0]       size_m1;
  logic             misalign;
  logic             dec_err;
  logic             accept;

  // Load shaping context captured at accept; no reset needed (data only)
  logic [3:0]       ld_size_q;
  logic             ld_sgn_q;
  logic [OFS_W-1:0] ld_ofs_q;

  // Right-align the addressed lanes of a beat, then zero- or sign-extend the
  // low size bytes to the full width. size is 1, 2, 4 or 8 here.
  function automatic logic [XLEN-1:0] load_extend(
    input logic [XLEN-1:0]  beat,
    input logic [OFS_W-1:0] ofs,
    input logic [3:0]       size,
    input logic             sgn
  );
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] r;
    logic            msb;
    int              nbits;
    sh    = beat >> {ofs, 3'b000};
    nbits = 8 * int'(size);
    case (size)
      4'd1:    msb = sh[7];
      4'd2:    msb = sh[15];
      4'd4:    msb = sh[31];
      default: msb = sh[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++) begin
      r[i] = (i < nbits) ? sh[i] : (sgn & msb);
    end
    return r;
  endfunction

  // Keep the low size bytes of the store data and move them to their lanes.
  function automatic logic [XLEN-1:0] store_place(
    input logic [XLEN-1:0]  wdata,
    input logic [OFS_W-1:0] ofs,
    input logic [3:0]       size
  );
    logic [XLEN-1:0] m;
    int              nbits;
    nbits = 8 * int'(size);
    for (int i = 0; i < XLEN; i++) begin
      m[i] = (i < nbits) ? wdata[i] : 1'b0;
    end
    return m << {ofs, 3'b000};
  endfunction

  // Byte enables ((1 << size) - 1) << ofs, built lane by lane so a full-beat
  // access does not overflow the shift.
  function automatic logic [NB-1:0] store_strb(
    input logic [OFS_W-1:0] ofs,
    input logic [3:0]       size
  );
    logic [NB-1:0] s;
    for (int i = 0; i < NB; i++) begin
      s[i] = (i >= int'(ofs)) && (i < int'(ofs) + int'(size));
    end
    return s;
  endfunction

  always_comb begin
    dec_size    = 4'd0;
    dec_sgn     = 1'b0;
    dec_code_ok = 1'b1;
    case (req_ctrl)
      4'b0000: dec_size = 4'd8;                    // LD
      4'b0001: dec_size = 4'd2;                    // LHU
      4'b0010: dec_size = 4'd1;                    // LBU
      4'b0011: begin dec_size = 4'd4; dec_sgn = 1'b1; end  // LW
      4'b0100: begin dec_size = 4'd2; dec_sgn = 1'b1; end  // LH
      4'b0101: dec_size = 4'd4;                    // LWU
      4'b0110: begin dec_size = 4'd1; dec_sgn = 1'b1; end  // LB
      4'b1000: dec_size = 4'd8;                    // SD
      4'b1001: dec_size = 4'd4;                    // SW
      4'b1010: dec_size = 4'd2;                    // SH
      4'b1011: dec_size = 4'd1;                    // SB
      default: dec_code_ok = 1'b0;
    endcase
  end

  assign dec_store   = req_ctrl[3];
  assign req_ofs     = req_addr[OFS_W-1:0];
  assign req_ofs_ext = {{(4-OFS_W){1'b0}}, req_ofs};
  assign size_m1     = dec_size - 4'd1;
  // Natural alignment: offset bits below the access size must be zero.
  assign misalign    = |(req_ofs_ext & size_m1);
  assign dec_err     = !dec_code_ok || (int'(dec_size) > NB) || misalign;
  assign accept      = (state == IDLE) && req_valid && req_ready;

  // Stage boundary: load shaping context, captured with the op
  always_ff @(posedge clk) begin
    if (accept) begin
      ld_size_q <= dec_size;
      ld_sgn_q  <= dec_sgn;
      ld_ofs_q  <= req_ofs;
    end
  end

  // Stage boundary: control FSM and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_strb    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (dec_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else if (dec_store) begin
              state   <= WR_WAIT;
              wr_req  <= 1'b1;
              wr_addr <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
              wr_data <= store_place(req_wdata, req_ofs, dec_size);
              wr_strb <= store_strb(req_ofs, dec_size);
            end else begin
              state   <= RD_WAIT;
              rd_req  <= 1'b1;
              rd_addr <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            end
          end
        end
        RD_WAIT: begin
          if (rd_finish) begin
            rd_req     <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= load_extend(rd_data, ld_ofs_q, ld_size_q, ld_sgn_q);
          end
        end
        WR_WAIT: begin
          if (wr_finish) begin
            wr_req     <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
          end
        end
        RESP: begin
          // Single response cycle; ready returns together with IDLE.
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu -- directed bench for mem_lsu with a 64-bit and a 32-bit instance.
// Stimulus pushes the expected response (data, err, cycle) into a per-instance
// queue; monitors pop and compare whenever resp_valid is seen.
// -----------------------------------------------------------------------------
module tb_mem_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 64-bit instance
  logic        req_valid, req_ready, rd_req, rd_finish, wr_req, wr_finish;
  logic        resp_valid, resp_err;
  logic [3:0]  req_ctrl;
  logic [63:0] req_addr, req_wdata, rd_addr, rd_data, wr_addr, wr_data, resp_data;
  logic [7:0]  wr_strb;

  // 32-bit instance
  logic        req_valid_32, req_ready_32, rd_req_32, rd_finish_32, wr_req_32, wr_finish_32;
  logic        resp_valid_32, resp_err_32;
  logic [3:0]  req_ctrl_32;
  logic [31:0] req_addr_32, req_wdata_32, rd_addr_32, rd_data_32, wr_addr_32, wr_data_32, resp_data_32;
  logic [3:0]  wr_strb_32;

  mem_lsu #(.XLEN(64), .ADDR_W(64)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_finish(rd_finish), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_finish(wr_finish),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  mem_lsu #(.XLEN(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_32), .req_ready(req_ready_32), .req_ctrl(req_ctrl_32),
    .req_addr(req_addr_32), .req_wdata(req_wdata_32),
    .rd_req(rd_req_32), .rd_addr(rd_addr_32), .rd_finish(rd_finish_32), .rd_data(rd_data_32),
    .wr_req(wr_req_32), .wr_addr(wr_addr_32), .wr_data(wr_data_32), .wr_strb(wr_strb_32),
    .wr_finish(wr_finish_32),
    .resp_valid(resp_valid_32), .resp_data(resp_data_32), .resp_err(resp_err_32)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic        chk_data;
    int          at;
  } exp_t;

  exp_t sb64[$];
  exp_t sb32[$];
  exp_t e64, e32;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: every resp_valid cycle must match the oldest expected response.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp64_unexpected: resp_valid at cycle %0d with nothing expected", cyc);
      end else begin
        e64 = sb64.pop_front();
        check("resp64_err", {63'd0, resp_err}, {63'd0, e64.err});
        if (e64.chk_data) check("resp64_data", resp_data, e64.data);
        check("resp64_cycle", 64'(cyc), 64'(e64.at));
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid_32) begin
      if (sb32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp32_unexpected: resp_valid at cycle %0d with nothing expected", cyc);
      end else begin
        e32 = sb32.pop_front();
        check("resp32_err", {63'd0, resp_err_32}, {63'd0, e32.err});
        if (e32.chk_data) check("resp32_data", {32'd0, resp_data_32}, e32.data);
        check("resp32_cycle", 64'(cyc), 64'(e32.at));
      end
    end
  end

  // Present an op in one cycle; returns just after the accepting edge.
  task automatic issue64(input logic [3:0] ctrl, input logic [63:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    check("ready_before_accept", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Load finishing after k request cycles; optionally keeps a second op
  // pending on req_valid to prove it is not taken while busy.
  task automatic load64(input logic [3:0] ctrl, input logic [63:0] addr, input logic [63:0] beat,
                        input int k, input logic [63:0] exp_addr, input logic [63:0] exp_data,
                        input logic hold);
    issue64(ctrl, addr, 64'h0);
    if (hold) begin
      req_ctrl = 4'b0000;
      req_addr = 64'h3000;
    end else begin
      req_valid = 1'b0;
    end
    sb64.push_back('{data: exp_data, err: 1'b0, chk_data: 1'b1, at: cyc + k});
    for (int j = 1; j <= k; j++) begin
      if (j == k) begin
        rd_finish = 1'b1;
        rd_data   = beat;
      end
      @(negedge clk);
      check("rd_req_high", {63'd0, rd_req}, 64'd1);
      check("rd_addr", rd_addr, exp_addr);
      if (hold) check("ready_low_busy", {63'd0, req_ready}, 64'd0);
      @(posedge clk);
      #1;
      rd_finish = 1'b0;
      rd_data   = 64'h0;
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("rd_req_dropped", {63'd0, rd_req}, 64'd0);
    check("ready_low_resp", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    check("ready_back_idle", {63'd0, req_ready}, 64'd1);
    check("no_extra_rd_req", {63'd0, rd_req}, 64'd0);
  endtask

  task automatic store64(input logic [3:0] ctrl, input logic [63:0] addr, input logic [63:0] wdata,
                         input int k, input logic [63:0] exp_addr, input logic [63:0] exp_data,
                         input logic [7:0] exp_strb);
    issue64(ctrl, addr, wdata);
    req_valid = 1'b0;
    sb64.push_back('{data: 64'h0, err: 1'b0, chk_data: 1'b0, at: cyc + k});
    for (int j = 1; j <= k; j++) begin
      if (j == k) wr_finish = 1'b1;
      @(negedge clk);
      check("wr_req_high", {63'd0, wr_req}, 64'd1);
      check("wr_addr", wr_addr, exp_addr);
      check("wr_data", wr_data, exp_data);
      check("wr_strb", {56'd0, wr_strb}, {56'd0, exp_strb});
      check("rd_req_quiet", {63'd0, rd_req}, 64'd0);
      @(posedge clk);
      #1;
      wr_finish = 1'b0;
    end
    @(negedge clk);
    check("wr_req_dropped", {63'd0, wr_req}, 64'd0);
    @(negedge clk);
  endtask

  task automatic error64(input logic [3:0] ctrl, input logic [63:0] addr);
    issue64(ctrl, addr, 64'hFFFF_FFFF_FFFF_FFFF);
    req_valid = 1'b0;
    sb64.push_back('{data: 64'h0, err: 1'b1, chk_data: 1'b1, at: cyc});
    @(negedge clk);
    check("err_no_rd_req", {63'd0, rd_req}, 64'd0);
    check("err_no_wr_req", {63'd0, wr_req}, 64'd0);
    @(negedge clk);
    check("err_ready_back", {63'd0, req_ready}, 64'd1);
    check("err_no_rd_req_later", {63'd0, rd_req}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   {63'd0, req_ready},  64'd1);
    check({tag, "_rd_req"},  {63'd0, rd_req},     64'd0);
    check({tag, "_wr_req"},  {63'd0, wr_req},     64'd0);
    check({tag, "_rd_addr"}, rd_addr,             64'd0);
    check({tag, "_wr_addr"}, wr_addr,             64'd0);
    check({tag, "_wr_data"}, wr_data,             64'd0);
    check({tag, "_wr_strb"}, {56'd0, wr_strb},    64'd0);
    check({tag, "_rvalid"},  {63'd0, resp_valid}, 64'd0);
    check({tag, "_rdata"},   resp_data,           64'd0);
    check({tag, "_rerr"},    {63'd0, resp_err},   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_ctrl = 4'h0; req_addr = 64'h0; req_wdata = 64'h0;
    rd_finish = 1'b0; rd_data = 64'h0; wr_finish = 1'b0;
    req_valid_32 = 1'b0; req_ctrl_32 = 4'h0; req_addr_32 = 32'h0; req_wdata_32 = 32'h0;
    rd_finish_32 = 1'b0; rd_data_32 = 32'h0; wr_finish_32 = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset32_ready", {63'd0, req_ready_32}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // LW sign-extended, finish after 3 request cycles
    load64(4'b0011, 64'h8000_0004, 64'h8765_4321_0000_0000, 3,
           64'h8000_0000, 64'hFFFF_FFFF_8765_4321, 1'b0);
    // SB into lane 3
    store64(4'b1011, 64'h1003, 64'hFFFF_FFFF_FFFF_FFAB, 2,
            64'h1000, 64'h0000_0000_AB00_0000, 8'h08);
    // Misaligned LH and illegal code
    error64(4'b0100, 64'h1001);
    error64(4'b0111, 64'h0);
    error64(4'b1100, 64'h0);
    error64(4'b1001, 64'hB002);
    // LBU at top lane, finish delayed, second op held on req_valid
    load64(4'b0010, 64'h2007, 64'h9C00_0000_0000_0000, 5,
           64'h2000, 64'h0000_0000_0000_009C, 1'b1);
    // More load shapes
    load64(4'b0001, 64'h6002, 64'h0000_0000_F00D_0000, 1,
           64'h6000, 64'h0000_0000_0000_F00D, 1'b0);
    load64(4'b0110, 64'h7005, 64'h0000_8000_0000_0000, 2,
           64'h7000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    load64(4'b0101, 64'h8004, 64'h8765_4321_0000_0000, 1,
           64'h8000, 64'h0000_0000_8765_4321, 1'b0);
    // More store shapes
    store64(4'b1000, 64'h9008, 64'h1122_3344_5566_7788, 1,
            64'h9008, 64'h1122_3344_5566_7788, 8'hFF);
    store64(4'b1010, 64'hA006, 64'hFFFF_FFFF_FFFF_BEEF, 3,
            64'hA000, 64'hBEEF_0000_0000_0000, 8'hC0);
    store64(4'b1001, 64'hB004, 64'h0000_0000_1234_5678, 1,
            64'hB000, 64'h1234_5678_0000_0000, 8'hF0);

    // Reset in the middle of a read, then a stray finish
    issue64(4'b0000, 64'h4000, 64'h0);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_rd_req", {63'd0, rd_req}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    rd_finish = 1'b1;
    rd_data   = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk);
    #1;
    rd_finish = 1'b0;
    rd_data   = 64'h0;
    @(negedge clk);
    check("stray_finish_rd_req", {63'd0, rd_req}, 64'd0);
    check("stray_finish_rvalid", {63'd0, resp_valid}, 64'd0);
    check("stray_finish_rdata", resp_data, 64'd0);
    load64(4'b0000, 64'h5008, 64'h0123_4567_89AB_CDEF, 1,
           64'h5008, 64'h0123_4567_89AB_CDEF, 1'b0);

    // 32-bit instance: LD is too wide, LW is a full beat
    @(negedge clk);
    req_valid_32 = 1'b1; req_ctrl_32 = 4'b0000; req_addr_32 = 32'h0;
    @(posedge clk);
    #1;
    req_valid_32 = 1'b0;
    sb32.push_back('{data: 64'h0, err: 1'b1, chk_data: 1'b1, at: cyc});
    @(negedge clk);
    check("x32_err_no_rd_req", {63'd0, rd_req_32}, 64'd0);
    check("x32_err_no_wr_req", {63'd0, wr_req_32}, 64'd0);
    @(negedge clk);
    req_valid_32 = 1'b1; req_ctrl_32 = 4'b0011; req_addr_32 = 32'h4;
    @(posedge clk);
    #1;
    req_valid_32 = 1'b0;
    sb32.push_back('{data: 64'h8000_0001, err: 1'b0, chk_data: 1'b1, at: cyc + 2});
    @(negedge clk);
    check("x32_rd_req", {63'd0, rd_req_32}, 64'd1);
    check("x32_rd_addr", {32'd0, rd_addr_32}, 64'h4);
    @(posedge clk);
    #1;
    rd_finish_32 = 1'b1;
    rd_data_32   = 32'h8000_0001;
    @(negedge clk);
    check("x32_rd_req_hold", {63'd0, rd_req_32}, 64'd1);
    @(posedge clk);
    #1;
    rd_finish_32 = 1'b0;
    rd_data_32   = 32'h0;
    @(negedge clk);
    check("x32_rd_req_dropped", {63'd0, rd_req_32}, 64'd0);

    repeat (3) @(negedge clk);
    check("sb64_drained", 64'(sb64.size()), 64'd0);
    check("sb32_drained", 64'(sb32.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
